seq_pattern_serializer: RTL and testbench

//  Transmit side of the serial sequence-detect link. Loads a pattern (up to W bits) and a length, then

---
 rtl/seq_link_pkg.sv | 20 ++
 rtl/seq_pattern_serializer_if.sv | 31 +++
 rtl/seq_shift_reg.sv | 39 +++
 rtl/seq_pattern_serializer.sv | 150 +++++++++++++++
 tb/tb_seq_pattern_serializer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_link_pkg.sv
// rtl/seq_link_pkg.sv - shared constants, state type and helpers for the serial sequence link
// Purpose: common definitions used by the pattern serializer and the sequence detector.
// Contents: PAT_W / LEN_W defaults, seq_state_t FSM encoding, clamp_len() length limiter.
package seq_link_pkg;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  // Requested lengths beyond the pattern width are sent as a full-width pattern.
  function automatic int clamp_len(input int len, input int max_w);
    return (len > max_w) ? max_w : len;
  endfunction

endpackage

// File: rtl/seq_pattern_serializer_if.sv
// rtl/seq_pattern_serializer_if.sv - load handshake and serial output bundle of the serializer
// Purpose: groups the frame-load handshake and the serial output signals.
// Signals: load_valid/load_ready/pat/len/rpt (load side), sdo/sdo_valid/frame_last/done/len_err (output side).
// Modports: master = stimulus/loader side, slave = serializer side.
interface seq_pattern_serializer_if
  import seq_link_pkg::*;
#(
  parameter int W     = PAT_W,
  parameter int LEN_W = seq_link_pkg::LEN_W
);
  logic             load_valid;
  logic             load_ready;
  logic [W-1:0]     pat;
  logic [LEN_W-1:0] len;
  logic [3:0]       rpt;
  logic             sdo;
  logic             sdo_valid;
  logic             frame_last;
  logic             done;
  logic             len_err;

  modport master (
    output load_valid, pat, len, rpt,
    input  load_ready, sdo, sdo_valid, frame_last, done, len_err
  );

  modport slave (
    input  load_valid, pat, len, rpt,
    output load_ready, sdo, sdo_valid, frame_last, done, len_err
  );
endinterface

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - loadable left-shift register with a variable tap at len-1
// Purpose: holds the pattern being serialized; tap presents the bit to be sent next.
// Ports: clk, rst (sync, active-high), en (advance enable), load/din (new pattern),
//        shift (advance one bit), len (active length selecting the tap), tap (next bit out).
module seq_shift_reg #(
  parameter int W     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             shift,
  input  logic [W-1:0]     din,
  input  logic [LEN_W-1:0] len,
  output logic             tap
);
  logic [W-1:0]     q;
  logic [W-1:0]     src;
  logic [LEN_W-1:0] idx;

  // On a load the first bit is taken straight from din so it can go out in the
  // cycle after the load; the register then keeps the remaining bits pre-shifted.
  assign src = load ? din : q;
  assign idx = (len == '0) ? '0 : len - LEN_W'(1);
  assign tap = |(src & (W'(1) << idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (load) begin
        q <= din << 1;
      end else if (shift) begin
        q <= q << 1;
      end
    end
  end
endmodule

// File: rtl/seq_pattern_serializer.sv
// rtl/seq_pattern_serializer.sv - MSB-first frame serializer with repeat count and idle gap
// Purpose: loads a pattern/length/repeat count and shifts it out one bit per enabled clock,
//          optionally repeating the frame with GAP_CYCLES idle cycles between repetitions.
// Ports: clk, rst (sync, active-high), ena (advance enable, freezes block when low),
//        bus (slave modport: load handshake in, registered serial output and status pulses out).
module seq_pattern_serializer
  import seq_link_pkg::*;
#(
  parameter int W          = PAT_W,
  parameter int LEN_W      = seq_link_pkg::LEN_W,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  seq_pattern_serializer_if.slave bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  seq_state_t       state, state_n;
  logic [LEN_W-1:0] bit_cnt, bit_cnt_n;
  logic [LEN_W-1:0] len_r, len_n, len_c, ld_len;
  logic [3:0]       rpt_cnt, rpt_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [W-1:0]     pat_r, pat_n, ld_pat;
  logic             sdo_q, sdo_valid_q, frame_last_q, done_q, len_err_q;
  logic             frame_last_n, done_n, len_err_n, sdo_n, sdo_valid_n;
  logic             accept, reload, sr_shift, sr_bit;

  assign bus.load_ready = ena && (state == IDLE);
  assign accept         = bus.load_valid && bus.load_ready;
  assign len_c          = LEN_W'(clamp_len(int'(bus.len), W));

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    rpt_cnt_n    = rpt_cnt;
    gap_cnt_n    = gap_cnt;
    len_n        = len_r;
    pat_n        = pat_r;
    ld_len       = len_r;
    ld_pat       = pat_r;
    reload       = 1'b0;
    sr_shift     = 1'b0;
    frame_last_n = 1'b0;
    done_n       = 1'b0;
    len_err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.len == '0) begin
            len_err_n = 1'b1;
          end else begin
            reload    = 1'b1;
            ld_len    = len_c;
            ld_pat    = bus.pat;
            len_n     = len_c;
            pat_n     = bus.pat;
            rpt_cnt_n = bus.rpt;
          end
        end
      end
      SHIFT: begin
        // bit_cnt is the number of bits still to follow the one on sdo now.
        if (bit_cnt != '0) begin
          sr_shift     = 1'b1;
          bit_cnt_n    = bit_cnt - LEN_W'(1);
          frame_last_n = (bit_cnt == LEN_W'(1));
        end else if (rpt_cnt != 4'd0) begin
          rpt_cnt_n = rpt_cnt - 4'd1;
          if (GAP_CYCLES > 0) begin
            state_n   = GAP;
            gap_cnt_n = GAP_W'(GAP_CYCLES - 1);
          end else begin
            reload = 1'b1;
          end
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          reload = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Starting a (re)transmission always emits the first bit immediately.
    if (reload) begin
      state_n      = SHIFT;
      bit_cnt_n    = ld_len - LEN_W'(1);
      frame_last_n = (ld_len == LEN_W'(1));
    end
  end

  assign sdo_valid_n = reload || sr_shift;
  assign sdo_n       = sdo_valid_n && sr_bit;

  seq_shift_reg #(
    .W     (W),
    .LEN_W (LEN_W)
  ) u_sreg (
    .clk   (clk),
    .rst   (rst),
    .en    (ena),
    .load  (reload),
    .shift (sr_shift),
    .din   (ld_pat),
    .len   (ld_len),
    .tap   (sr_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rpt_cnt      <= '0;
      gap_cnt      <= '0;
      len_r        <= '0;
      pat_r        <= '0;
      sdo_q        <= 1'b0;
      sdo_valid_q  <= 1'b0;
      frame_last_q <= 1'b0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else if (ena) begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      rpt_cnt      <= rpt_cnt_n;
      gap_cnt      <= gap_cnt_n;
      len_r        <= len_n;
      pat_r        <= pat_n;
      sdo_q        <= sdo_n;
      sdo_valid_q  <= sdo_valid_n;
      frame_last_q <= frame_last_n;
      done_q       <= done_n;
      len_err_q    <= len_err_n;
    end
  end

  assign bus.sdo        = sdo_q;
  assign bus.sdo_valid  = sdo_valid_q;
  assign bus.frame_last = frame_last_q;
  // Pulses are suppressed while frozen; the held register re-presents them on resume.
  assign bus.done       = done_q && ena;
  assign bus.len_err    = len_err_q && ena;
endmodule

// File: tb/tb_seq_pattern_serializer.sv
// tb/tb_seq_pattern_serializer.sv - scoreboard testbench for seq_pattern_serializer
module tb_seq_pattern_serializer;
  typedef struct {
    int b;
    int l;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic ena_q = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  exp_t q0[$];
  exp_t qg[$];
  int   d0[$];
  int   dg[$];
  int   e0[$];
  int   last0 = 0;

  seq_pattern_serializer_if #(.W(8), .LEN_W(4)) bus0 ();
  seq_pattern_serializer_if #(.W(8), .LEN_W(4)) busg ();

  seq_pattern_serializer #(.W(8), .LEN_W(4), .GAP_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .ena (ena), .bus (bus0)
  );
  seq_pattern_serializer #(.W(8), .LEN_W(4), .GAP_CYCLES(2)) dutg (
    .clk (clk), .rst (rst), .ena (ena), .bus (busg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ena_q <= ena;
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the back-to-back instance.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (cyc > 0) begin
      if (bus0.sdo_valid && ena_q) begin
        if (q0.size() == 0) check("bit0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          check("sdo0", int'(bus0.sdo), e.b);
          check("last0", int'(bus0.frame_last), e.l);
          check("bit0_cycle", cyc, e.c);
          last0 = int'(bus0.sdo);
        end
      end else if (bus0.sdo_valid) begin
        check("hold_sdo0", int'(bus0.sdo), last0);
      end else begin
        check("idle_sdo0", int'(bus0.sdo), 0);
        check("idle_last0", int'(bus0.frame_last), 0);
      end
      if (bus0.done) begin
        if (d0.size() == 0) check("done0_unexpected", 1, 0);
        else check("done0_cycle", cyc, d0.pop_front());
      end
      if (bus0.len_err) begin
        if (e0.size() == 0) check("len_err_unexpected", 1, 0);
        else check("len_err_cycle", cyc, e0.pop_front());
      end
    end
  end

  // Monitor for the gapped instance.
  always @(negedge clk) begin : mong
    exp_t e;
    if (cyc > 0) begin
      if (busg.sdo_valid && ena_q) begin
        if (qg.size() == 0) check("bitg_unexpected", 1, 0);
        else begin
          e = qg.pop_front();
          check("sdog", int'(busg.sdo), e.b);
          check("lastg", int'(busg.frame_last), e.l);
          check("bitg_cycle", cyc, e.c);
        end
      end else if (!busg.sdo_valid) begin
        check("idle_sdog", int'(busg.sdo), 0);
      end
      if (busg.done) begin
        if (dg.size() == 0) check("doneg_unexpected", 1, 0);
        else check("doneg_cycle", cyc, dg.pop_front());
      end
      if (busg.len_err) check("len_errg_unexpected", 1, 0);
    end
  end

  // Present a load at the next edge; n returns that edge's index (first bit is sampled at cyc==n).
  task automatic do_load(input int which, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, output int n);
    @(negedge clk);
    if (which == 0) begin
      check("load_ready0", int'(bus0.load_ready), 1);
      bus0.pat = p; bus0.len = l; bus0.rpt = r; bus0.load_valid = 1'b1;
    end else begin
      check("load_readyg", int'(busg.load_ready), 1);
      busg.pat = p; busg.len = l; busg.rpt = r; busg.load_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    n = cyc;
    bus0.load_valid = 1'b0;
    busg.load_valid = 1'b0;
    bus0.pat = 8'hFF; bus0.len = 4'd7; bus0.rpt = 4'd9;
    busg.pat = 8'hFF; busg.len = 4'd7; busg.rpt = 4'd9;
  endtask

  // Hand-written bit string (MSB first) repeated rpt+1 times with gap idle cycles between.
  task automatic push_frame(input int which, input logic [15:0] bits, input int nbits,
                            input int rpt, input int gap, input int n);
    exp_t e;
    for (int r = 0; r <= rpt; r++) begin
      for (int j = 0; j < nbits; j++) begin
        e.b = int'(bits[nbits-1-j]);
        e.l = (j == nbits - 1) ? 1 : 0;
        e.c = n + r * (nbits + gap) + j;
        if (which == 0) q0.push_back(e); else qg.push_back(e);
      end
    end
    if (which == 0) d0.push_back(n + nbits * (rpt + 1) + gap * rpt);
    else dg.push_back(n + nbits * (rpt + 1) + gap * rpt);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() + qg.size() + d0.size() + dg.size() + e0.size()) != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("drain_pending", q0.size() + qg.size() + d0.size() + dg.size() + e0.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    exp_t e;
    bus0.load_valid = 1'b0; bus0.pat = '0; bus0.len = '0; bus0.rpt = '0;
    busg.load_valid = 1'b0; busg.pat = '0; busg.len = '0; busg.rpt = '0;
    rst = 1'b1;
    ena = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sdo", int'(bus0.sdo), 0);
    check("rst_sdo_valid", int'(bus0.sdo_valid), 0);
    check("rst_frame_last", int'(bus0.frame_last), 0);
    check("rst_done", int'(bus0.done), 0);
    check("rst_len_err", int'(bus0.len_err), 0);
    check("rst_load_ready", int'(bus0.load_ready), 1);
    check("rst_load_readyg", int'(busg.load_ready), 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Length 3, single shot.
    do_load(0, 8'b101, 4'd3, 4'd0, n);
    push_frame(0, 16'b101, 3, 0, 0, n);
    drain();

    // Length 6, three repetitions back to back.
    do_load(0, 8'b110011, 4'd6, 4'd2, n);
    push_frame(0, 16'b110011, 6, 2, 0, n);
    drain();

    // Same frame with a 2-cycle gap between repetitions.
    do_load(1, 8'b110011, 4'd6, 4'd2, n);
    push_frame(1, 16'b110011, 6, 2, 2, n);
    drain();

    // Zero length is rejected.
    do_load(0, 8'hFF, 4'd0, 4'd0, n);
    e0.push_back(n);
    drain();
    check("len0_ready_after", int'(bus0.load_ready), 1);

    // Oversize length is clamped to 8.
    do_load(0, 8'hA5, 4'd12, 4'd0, n);
    push_frame(0, 16'b10100101, 8, 0, 0, n);
    drain();

    // Enable pause after bit 2 for 3 cycles.
    do_load(0, 8'b1101, 4'd4, 4'd0, n);
    e.b = 1; e.l = 0; e.c = n;     q0.push_back(e);
    e.b = 1; e.l = 0; e.c = n + 1; q0.push_back(e);
    e.b = 0; e.l = 0; e.c = n + 5; q0.push_back(e);
    e.b = 1; e.l = 1; e.c = n + 6; q0.push_back(e);
    d0.push_back(n + 7);
    @(posedge clk);
    #1;
    ena = 1'b0;
    @(negedge clk);
    check("pause_load_ready", int'(bus0.load_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;
    drain();

    // Reset during bit 3 of an 8-bit frame.
    do_load(0, 8'b10110110, 4'd8, 4'd0, n);
    e.b = 1; e.l = 0; e.c = n;     q0.push_back(e);
    e.b = 0; e.l = 0; e.c = n + 1; q0.push_back(e);
    e.b = 1; e.l = 0; e.c = n + 2; q0.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_sdo_valid", int'(bus0.sdo_valid), 0);
    check("abort_load_ready", int'(bus0.load_ready), 1);
    drain();

    do_load(0, 8'b0000, 4'd4, 4'd0, n);
    push_frame(0, 16'b0000, 4, 0, 0, n);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
